// File: rtl/seg7_scan_decoder.sv
// Receive-side 7-segment scan decoder: samples a multiplexed active-low segment bus,
// qualifies each digit by stability, decodes it and assembles complete multi-digit frames.
module seg7_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    iENABLE,
    input  logic [6:0]              iSEG,
    input  logic [NUM_DIGITS-1:0]   iDIG_EN,
    output logic [4*NUM_DIGITS-1:0] oVALUE,
    output logic [NUM_DIGITS-1:0]   oBLANK,
    output logic [NUM_DIGITS-1:0]   oERR,
    output logic                    oVALID,
    output logic                    oSYNC_ERR
);

    localparam int unsigned IdxW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0]  StableMax = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {StIdle, StCount, StHeld} state_e;

    state_e                  state;
    logic [7:0]              cnt;
    logic [6:0]              seg_s;
    logic [NUM_DIGITS-1:0]   dig_s;
    logic [6:0]              trk_seg;
    logic [NUM_DIGITS-1:0]   trk_dig;
    logic [NUM_DIGITS-1:0]   mask;
    logic [4*NUM_DIGITS-1:0] sh_value;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [NUM_DIGITS-1:0]   sh_err;

    logic [3:0]              n_act;
    logic [IdxW-1:0]         act_idx;
    logic [3:0]              dec_nib;
    logic                    dec_blank;
    logic                    dec_err;
    logic                    same;
    logic                    reeval;
    logic                    capture;
    logic                    mask_full;
    logic [7:0]              cnt_inc;
    logic [NUM_DIGITS-1:0]   cap_mask;

    always_comb begin
        n_act   = '0;
        act_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!dig_s[i]) begin
                n_act   = n_act + 4'd1;
                act_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        dec_nib   = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_s)
            7'b1000000: dec_nib = 4'h0;
            7'b1111001: dec_nib = 4'h1;
            7'b0100100: dec_nib = 4'h2;
            7'b0110000: dec_nib = 4'h3;
            7'b0011001: dec_nib = 4'h4;
            7'b0010010: dec_nib = 4'h5;
            7'b0000010: dec_nib = 4'h6;
            7'b1111000: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0011000: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b0000011: dec_nib = 4'hB;
            7'b1000110: dec_nib = 4'hC;
            7'b0100001: dec_nib = 4'hD;
            7'b0000110: dec_nib = 4'hE;
            7'b0001110: dec_nib = 4'hF;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_err = 1'b1;
        endcase
    end

    assign same      = (seg_s == trk_seg) && (dig_s == trk_dig);
    assign reeval    = (state == StIdle) || !same;
    assign cnt_inc   = cnt + 8'd1;
    assign capture   = iENABLE && (state == StCount) && same && (cnt_inc == StableMax);
    assign mask_full = &mask;
    assign cap_mask  = capture ? (NUM_DIGITS'(1) << act_idx) : '0;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            // Sample registers start at the idle bus level so no phantom strobes follow reset.
            seg_s     <= '1;
            dig_s     <= '1;
            trk_seg   <= '0;
            trk_dig   <= '0;
            state     <= StIdle;
            cnt       <= '0;
            mask      <= '0;
            sh_value  <= '0;
            sh_blank  <= '0;
            sh_err    <= '0;
            oVALUE    <= '0;
            oBLANK    <= '0;
            oERR      <= '0;
            oVALID    <= 1'b0;
            oSYNC_ERR <= 1'b0;
        end else begin
            seg_s     <= iSEG;
            dig_s     <= iDIG_EN;
            oVALID    <= 1'b0;
            oSYNC_ERR <= 1'b0;
            if (!iENABLE) begin
                state <= StIdle;
                cnt   <= '0;
                mask  <= '0;
            end else begin
                if (mask_full) begin
                    oVALUE <= sh_value;
                    oBLANK <= sh_blank;
                    oERR   <= sh_err;
                    oVALID <= 1'b1;
                    mask   <= cap_mask;
                end else begin
                    mask   <= mask | cap_mask;
                end

                if (capture) begin
                    sh_value[4*act_idx +: 4] <= dec_nib;
                    sh_blank[act_idx]        <= dec_blank;
                    sh_err[act_idx]          <= dec_err;
                end

                if (reeval) begin
                    if (n_act == 4'd1) begin
                        state   <= StCount;
                        cnt     <= 8'd1;
                        trk_seg <= seg_s;
                        trk_dig <= dig_s;
                    end else begin
                        state     <= StIdle;
                        cnt       <= '0;
                        oSYNC_ERR <= (n_act > 4'd1);
                    end
                end else if (state == StCount) begin
                    if (cnt_inc == StableMax) begin
                        state <= StHeld;
                        cnt   <= StableMax;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: table of full-frame scans plus hand-written
// sequences for short dwell, strobe collisions, reset mid-frame and enable drop.
module tb_seg7_scan_decoder;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iENABLE;
    logic [6:0]  iSEG;
    logic [3:0]  iDIG_EN;
    logic [15:0] oVALUE;
    logic [3:0]  oBLANK;
    logic [3:0]  oERR;
    logic        oVALID;
    logic        oSYNC_ERR;

    localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001, P5 = 7'b0010010, P6 = 7'b0000010, P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000, P9 = 7'b0011000, PA = 7'b0001000, PB = 7'b0000011;
    localparam logic [6:0] PC = 7'b1000110, PD = 7'b0100001, PE = 7'b0000110, PF = 7'b0001110;
    localparam logic [6:0] PBLANK = 7'b1111111, PBAD = 7'b1010101;

    seg7_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (8)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iENABLE   (iENABLE),
        .iSEG      (iSEG),
        .iDIG_EN   (iDIG_EN),
        .oVALUE    (oVALUE),
        .oBLANK    (oBLANK),
        .oERR      (oERR),
        .oVALID    (oVALID),
        .oSYNC_ERR (oSYNC_ERR)
    );

    always #5 iCLK = ~iCLK;

    int n_valid_seen = 0;
    int n_sync_seen  = 0;
    always @(negedge iCLK) begin
        if (oVALID === 1'b1) n_valid_seen++;
        if (oSYNC_ERR === 1'b1) n_sync_seen++;
    end

    typedef struct {
        logic [3:0][6:0] seg;
        int              dwell;
        int              exp_nvalid;
        logic [15:0]     exp_value;
        logic [3:0]      exp_blank;
        logic [3:0]      exp_err;
    } vec_t;

    vec_t vecs[6];
    int   nvec  = 0;
    int   nfail = 0;
    int   v0;
    int   s0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs are always changed 1 time unit after a rising edge.
    task automatic scan_digit(input int k, input logic [6:0] seg, input int dwell);
        iDIG_EN = ~(4'b0001 << k);
        iSEG    = seg;
        repeat (dwell) @(posedge iCLK);
        #1;
    endtask

    task automatic idle(input int n);
        iDIG_EN = 4'b1111;
        iSEG    = 7'b1111111;
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    initial begin
        vecs[0] = '{seg: {P3, P2, P1, P0}, dwell: 20, exp_nvalid: 1,
                    exp_value: 16'h3210, exp_blank: 4'b0000, exp_err: 4'b0000};
        vecs[1] = '{seg: {PBAD, PA, PBLANK, P4}, dwell: 20, exp_nvalid: 1,
                    exp_value: 16'h0A04, exp_blank: 4'b0010, exp_err: 4'b1000};
        vecs[2] = '{seg: {PC, PD, PE, PF}, dwell: 8, exp_nvalid: 1,
                    exp_value: 16'hCDEF, exp_blank: 4'b0000, exp_err: 4'b0000};
        vecs[3] = '{seg: {P9, P7, P6, P5}, dwell: 7, exp_nvalid: 0,
                    exp_value: 16'hCDEF, exp_blank: 4'b0000, exp_err: 4'b0000};
        vecs[4] = '{seg: {P9, P7, P6, P5}, dwell: 20, exp_nvalid: 1,
                    exp_value: 16'h9765, exp_blank: 4'b0000, exp_err: 4'b0000};
        vecs[5] = '{seg: {P3, PA, P1, PB}, dwell: 12, exp_nvalid: 1,
                    exp_value: 16'h3A1B, exp_blank: 4'b0000, exp_err: 4'b0000};

        iRST    = 1'b1;
        iENABLE = 1'b0;
        iSEG    = 7'b1111111;
        iDIG_EN = 4'b1111;
        repeat (3) @(posedge iCLK);
        #1;
        iRST = 1'b0;
        check("reset value", 32'(oVALUE), 32'h0);
        check("reset blank", 32'(oBLANK), 32'h0);
        check("reset err", 32'(oERR), 32'h0);
        check("reset valid", 32'(oVALID), 32'h0);
        check("reset sync_err", 32'(oSYNC_ERR), 32'h0);

        iENABLE = 1'b1;
        idle(2);

        for (int r = 0; r < 6; r++) begin
            v0 = n_valid_seen;
            s0 = n_sync_seen;
            for (int k = 0; k < 4; k++) scan_digit(k, vecs[r].seg[k], vecs[r].dwell);
            idle(5);
            check($sformatf("row%0d valid count", r), n_valid_seen - v0, vecs[r].exp_nvalid);
            check($sformatf("row%0d sync count", r), n_sync_seen - s0, 0);
            check($sformatf("row%0d value", r), 32'(oVALUE), 32'(vecs[r].exp_value));
            check($sformatf("row%0d blank", r), 32'(oBLANK), 32'(vecs[r].exp_blank));
            check($sformatf("row%0d err", r), 32'(oERR), 32'(vecs[r].exp_err));
        end

        // Digit 2 dwells one cycle short of the threshold; rescan supplies it.
        v0 = n_valid_seen;
        scan_digit(0, P1, 20);
        scan_digit(1, P2, 20);
        scan_digit(2, P7, 7);
        scan_digit(3, P4, 20);
        idle(5);
        check("short dwell valid count", n_valid_seen - v0, 0);
        check("short dwell hold value", 32'(oVALUE), 32'h3A1B);
        v0 = n_valid_seen;
        scan_digit(0, P1, 20);
        scan_digit(1, P2, 20);
        scan_digit(2, P5, 20);
        scan_digit(3, P4, 20);
        idle(5);
        check("rescan valid count", n_valid_seen - v0, 1);
        check("rescan value", 32'(oVALUE), 32'h4521);
        iENABLE = 1'b0;
        idle(2);
        iENABLE = 1'b1;
        idle(2);

        // Two strobes low for three cycles.
        v0 = n_valid_seen;
        s0 = n_sync_seen;
        iDIG_EN = 4'b1100;
        iSEG    = P8;
        repeat (3) @(posedge iCLK);
        #1;
        idle(4);
        check("collision sync count", n_sync_seen - s0, 3);
        check("collision valid count", n_valid_seen - v0, 0);
        v0 = n_valid_seen;
        s0 = n_sync_seen;
        scan_digit(0, PA, 20);
        scan_digit(1, PB, 20);
        scan_digit(2, PC, 20);
        scan_digit(3, PD, 20);
        idle(5);
        check("recovery valid count", n_valid_seen - v0, 1);
        check("recovery sync count", n_sync_seen - s0, 0);
        check("recovery value", 32'(oVALUE), 32'hDCBA);

        // Reset after two captures; partial frame must not survive.
        scan_digit(0, P1, 20);
        scan_digit(1, P2, 20);
        iRST    = 1'b1;
        iDIG_EN = 4'b1111;
        iSEG    = 7'b1111111;
        repeat (2) @(posedge iCLK);
        #1;
        iRST = 1'b0;
        check("midreset value", 32'(oVALUE), 32'h0);
        check("midreset blank", 32'(oBLANK), 32'h0);
        check("midreset err", 32'(oERR), 32'h0);
        v0 = n_valid_seen;
        scan_digit(2, P8, 20);
        scan_digit(3, P8, 20);
        idle(5);
        check("post-reset half scan valid", n_valid_seen - v0, 0);
        scan_digit(0, P8, 20);
        scan_digit(1, P8, 20);
        idle(5);
        check("post-reset valid count", n_valid_seen - v0, 1);
        check("post-reset value", 32'(oVALUE), 32'h8888);

        // Enable dropped mid-frame while a strobe collision is on the bus.
        scan_digit(0, PF, 20);
        scan_digit(1, PE, 20);
        iENABLE = 1'b0;
        v0 = n_valid_seen;
        s0 = n_sync_seen;
        iDIG_EN = 4'b1100;
        iSEG    = P8;
        repeat (10) @(posedge iCLK);
        #1;
        idle(2);
        check("disabled valid count", n_valid_seen - v0, 0);
        check("disabled sync count", n_sync_seen - s0, 0);
        check("disabled hold value", 32'(oVALUE), 32'h8888);
        iENABLE = 1'b1;
        scan_digit(2, PD, 20);
        scan_digit(3, PC, 20);
        idle(5);
        check("mask cleared by disable", n_valid_seen - v0, 0);
        scan_digit(0, PF, 20);
        scan_digit(1, PE, 20);
        scan_digit(2, PD, 20);
        scan_digit(3, PC, 20);
        idle(5);
        check("re-enabled valid count", n_valid_seen - v0, 1);
        check("re-enabled value", 32'(oVALUE), 32'hCDEF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
